// File: rtl/vrf_pkg.sv
`default_nettype none
// ============================================================================
// Package     : vrf_pkg
// Description : Shared sizing constants, types and helpers for the vector
//               register file write-back path.
//               Optional feature macro used by the arbiter top:
//               VRF_WB_SCOREBOARD_EN (busy-register scoreboard).
// Contents    : VRF_WIDTH  - lanes per vector and bits per lane
//               NREG       - number of vector registers
//               ADDR_W     - register address width
//               VEC_W      - flat bit width of one vector
//               vreg_addr_t, vec_t, rr_next()
// Revision    : 1.0 - initial release
// ============================================================================
package vrf_pkg;

    localparam int VRF_WIDTH = 16;
    localparam int NREG      = 32;
    localparam int ADDR_W    = $clog2(NREG);
    localparam int VEC_W     = VRF_WIDTH * VRF_WIDTH;

    typedef logic [ADDR_W-1:0]                  vreg_addr_t;
    typedef logic [VRF_WIDTH-1:0][VRF_WIDTH-1:0] vec_t;

    // Successor of a requester index in a ring of n requesters.
    function automatic int rr_next(input int idx, input int n);
        return (idx + 1 >= n) ? 0 : idx + 1;
    endfunction

endpackage : vrf_pkg
`default_nettype wire

// File: rtl/vrf_wb_arbiter_if.sv
`default_nettype none
// ============================================================================
// Interface   : vrf_wb_arbiter_if
// Description : Bundles the requester handshake, the VRF write port and the
//               scoreboard decode signals of the write-back arbiter.
// Modports    : master - requesters / decode side (drives requests, sb_*, rs*)
//               slave  - arbiter side (drives req_ready, RD/WD/WEV, rs_busy,
//                        sb_err)
// Signals     : req_valid/req_rd/req_wd/req_ready per requester,
//               RD/WD/WEV registered VRF write port,
//               sb_set/sb_rd, rs1/rs2/rs3, rs_busy, sb_err
// Revision    : 1.0 - initial release
// ============================================================================
interface vrf_wb_arbiter_if
    import vrf_pkg::*;
#(
    parameter int NREQ   = 3,
    parameter int WIDTH  = VRF_WIDTH,
    parameter int ADDR_W = vrf_pkg::ADDR_W
);

    logic [NREQ-1:0]                         req_valid;
    logic [NREQ-1:0][ADDR_W-1:0]             req_rd;
    logic [NREQ-1:0][WIDTH-1:0][WIDTH-1:0]   req_wd;
    logic [NREQ-1:0]                         req_ready;

    logic [ADDR_W-1:0]                       RD;
    logic [WIDTH-1:0][WIDTH-1:0]             WD;
    logic                                    WEV;

    logic                                    sb_set;
    logic [ADDR_W-1:0]                       sb_rd;
    logic [ADDR_W-1:0]                       rs1;
    logic [ADDR_W-1:0]                       rs2;
    logic [ADDR_W-1:0]                       rs3;
    logic [2:0]                              rs_busy;
    logic                                    sb_err;

    modport master (
        output req_valid, req_rd, req_wd, sb_set, sb_rd, rs1, rs2, rs3,
        input  req_ready, RD, WD, WEV, rs_busy, sb_err
    );

    modport slave (
        input  req_valid, req_rd, req_wd, sb_set, sb_rd, rs1, rs2, rs3,
        output req_ready, RD, WD, WEV, rs_busy, sb_err
    );

endinterface : vrf_wb_arbiter_if
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin picker. The first asserted request
//               found scanning from ptr_i upwards (wrapping at N) is granted.
// Ports       : req_i     [N]   request vector
//               ptr_i     [IW]  highest-priority index (must be < N)
//               gnt_o     [N]   one-hot grant, zero when no request
//               gnt_idx_o [IW]  index of the granted requester
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
    parameter int N = 3
) (
    input  wire logic [N-1:0]                    req_i,
    input  wire logic [((N > 1) ? $clog2(N) : 1)-1:0] ptr_i,
    output logic      [N-1:0]                    gnt_o,
    output logic      [((N > 1) ? $clog2(N) : 1)-1:0] gnt_idx_o
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    always_comb begin
        logic found;
        int   j;
        gnt_o     = '0;
        gnt_idx_o = '0;
        found     = 1'b0;
        for (int k = 0; k < N; k++) begin
            // Wrap without a modulo so the scan stays a small adder + compare.
            j = int'(ptr_i) + k;
            if (j >= N) begin
                j = j - N;
            end
            if (!found && req_i[j]) begin
                gnt_o[j]  = 1'b1;
                gnt_idx_o = IW'(j);
                found     = 1'b1;
            end
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/vrf_wb_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : vrf_wb_arbiter
// Description : Shares the single VRF write port among NREQ producers with a
//               round-robin valid/ready grant and a registered write stage.
//               An optional busy-register scoreboard reports pending writes to
//               decode for RAW stalls and flags WAW issue errors.
// Macro       : VRF_WB_SCOREBOARD_EN - when defined the scoreboard (busy[],
//               rs_busy, sb_err) is built; otherwise rs_busy and sb_err are 0
//               and sb_set/sb_rd/rs* are ignored.
// Ports       : clk  - clock, all logic on posedge
//               rst  - synchronous, active-low reset
//               bus  - vrf_wb_arbiter_if.slave (requests, VRF write port,
//                      scoreboard decode signals)
// Revision    : 1.0 - initial release
// ============================================================================
module vrf_wb_arbiter #(
    parameter int WIDTH = vrf_pkg::VRF_WIDTH,
    parameter int NREQ  = 3,
    parameter int NREG  = vrf_pkg::NREG
) (
    input  wire logic         clk,
    input  wire logic         rst,
    vrf_wb_arbiter_if.slave   bus
);

    import vrf_pkg::*;

    localparam int AW = $clog2(NREG);
    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    logic [IW-1:0]   rr_ptr_q;
    logic [NREQ-1:0] w_gnt;
    logic [IW-1:0]   w_gnt_idx;
    logic            w_hs;

    rr_arbiter #(
        .N (NREQ)
    ) u_rr_arbiter (
        .req_i     (bus.req_valid),
        .ptr_i     (rr_ptr_q),
        .gnt_o     (w_gnt),
        .gnt_idx_o (w_gnt_idx)
    );

    // Grants are suppressed while reset is asserted so no handshake can be
    // observed by a requester during reset.
    assign bus.req_ready = rst ? w_gnt : '0;

    // The grant is a subset of the valid vector, so any grant is a handshake.
    assign w_hs = |bus.req_ready;

    // ------------------------------------------------------------------
    // Registered write stage
    // ------------------------------------------------------------------
    logic                         wev_q;
    logic [AW-1:0]                rd_q;
    logic [WIDTH-1:0][WIDTH-1:0]  wd_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            wev_q    <= 1'b0;
            rd_q     <= '0;
            wd_q     <= '0;
            rr_ptr_q <= '0;
        end else begin
            wev_q <= w_hs;
            if (w_hs) begin
                rd_q     <= bus.req_rd[w_gnt_idx];
                wd_q     <= bus.req_wd[w_gnt_idx];
                rr_ptr_q <= IW'(rr_next(int'(w_gnt_idx), NREQ));
            end
        end
    end

    assign bus.WEV = wev_q;
    assign bus.RD  = rd_q;
    assign bus.WD  = wd_q;

    // ------------------------------------------------------------------
    // Scoreboard
    // ------------------------------------------------------------------
`ifdef VRF_WB_SCOREBOARD_EN
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic            sb_err_q;
    logic            sb_err_d;
    logic            w_clr_hit;

    // A set landing on the register being committed this edge is a fresh
    // tracked write, not a WAW conflict.
    assign w_clr_hit = wev_q && (rd_q == bus.sb_rd);

    always_comb begin
        busy_d   = busy_q;
        sb_err_d = sb_err_q;
        if (wev_q) begin
            busy_d[rd_q] = 1'b0;
        end
        // Applied after the clear so a same-edge set wins.
        if (bus.sb_set) begin
            if (busy_q[bus.sb_rd] && !w_clr_hit) begin
                sb_err_d = 1'b1;
            end
            busy_d[bus.sb_rd] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            busy_q   <= '0;
            sb_err_q <= 1'b0;
        end else begin
            busy_q   <= busy_d;
            sb_err_q <= sb_err_d;
        end
    end

    // The committing register still counts as busy during its write cycle,
    // since the VRF only returns the new value one cycle later.
    assign bus.rs_busy[0] = busy_q[bus.rs1] | (wev_q && (rd_q == bus.rs1));
    assign bus.rs_busy[1] = busy_q[bus.rs2] | (wev_q && (rd_q == bus.rs2));
    assign bus.rs_busy[2] = busy_q[bus.rs3] | (wev_q && (rd_q == bus.rs3));
    assign bus.sb_err     = sb_err_q;
`else
    logic w_sb_unused;

    assign w_sb_unused  = ^{bus.sb_set, bus.sb_rd, bus.rs1, bus.rs2, bus.rs3};
    assign bus.rs_busy  = 3'b000;
    assign bus.sb_err   = 1'b0;
`endif

endmodule : vrf_wb_arbiter
`default_nettype wire
